// File: rtl/median_window_ctrl_if.sv
// Pixel-stream, window and filter-control signals shared by the window controller and its neighbours.
interface median_window_ctrl_if;
    logic [11:0] pixIn;
    logic        pixValid;
    logic        frameStart;
    logic        pixReady;
    logic        enMedian;
    logic [11:0] winLu, winLm, winLd;
    logic [11:0] winMu, winMm, winMd;
    logic [11:0] winRu, winRm, winRd;
    logic        winValid;
    logic        useMedian;
    logic        outValid;
    logic        outLast;

    // Controller side
    modport slave (
        input  pixIn, pixValid, frameStart, enMedian,
        output pixReady,
        output winLu, winLm, winLd, winMu, winMm, winMd, winRu, winRm, winRd,
        output winValid, useMedian, outValid, outLast
    );

    // Source / sink side
    modport master (
        output pixIn, pixValid, frameStart, enMedian,
        input  pixReady,
        input  winLu, winLm, winLd, winMu, winMm, winMd, winRu, winRm, winRd,
        input  winValid, useMedian, outValid, outLast
    );
endinterface

// File: rtl/median_window_ctrl.sv
// 3x3 window generator for a raster pixel stream feeding a median filter,
// with frame sequencing, end-of-frame flush and filter output-select tracking.
module median_window_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int FILT_LAT = 5
) (
    input  logic                 readClk,
    input  logic                 rstN,
    median_window_ctrl_if.slave  bus
);
    localparam int          AW         = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [10:0] X_LAST     = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST     = 11'(IMG_H - 1);
    localparam logic [10:0] FLUSH_LAST = 11'(IMG_W);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nx;

    logic [10:0]   x, y, cx, cy, flush_cnt;
    logic          ready_q;
    logic          accept, start, advance, emit, clear_pipe;
    logic [11:0]   shift_pix;
    logic [AW-1:0] addr;
    logic [11:0]   line0 [IMG_W];
    logic [11:0]   line1 [IMG_W];
    logic [11:0]   lu, lm, ld, mu, mm, md, ru, rm, rd;
    logic          win_valid, win_border, win_last;
    logic [2:0]    pipe [FILT_LAT];

    // State register
    always_ff @(posedge readClk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: a frameStart outside FLUSH always (re)starts a frame in FILL
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = FILL;
            FILL:  if (start) state_nx = FILL;
                   else if (accept && x == '0 && y == 11'd1) state_nx = RUN;
            RUN:   if (start) state_nx = FILL;
                   else if (accept && x == X_LAST && y == Y_LAST) state_nx = FLUSH;
            FLUSH: if (flush_cnt == FLUSH_LAST) state_nx = IDLE;
        endcase
    end

    // Output decode: datapath strobes per state; FLUSH ticks shift zeros in
    always_comb begin
        accept     = bus.pixValid && ready_q;
        start      = accept && bus.frameStart && (state != FLUSH);
        advance    = 1'b0;
        emit       = 1'b0;
        clear_pipe = 1'b0;
        shift_pix  = bus.pixIn;
        unique case (state)
            IDLE:  advance = start;
            FILL:  begin advance = accept; clear_pipe = start; end
            RUN:   begin advance = accept; emit = accept && !bus.frameStart; clear_pipe = start; end
            FLUSH: begin advance = 1'b1; emit = 1'b1; shift_pix = '0; end
        endcase
    end

    // A restarting pixel is column 0 regardless of where the counters were
    assign addr = start ? '0 : x[AW-1:0];

    // Ready is registered from the next state so it is low during reset and all of FLUSH
    always_ff @(posedge readClk or negedge rstN) begin
        if (!rstN) ready_q <= 1'b0;
        else       ready_q <= (state_nx != FLUSH);
    end

    // Input position and flush tick counters
    always_ff @(posedge readClk or negedge rstN) begin
        if (!rstN) begin
            x         <= '0;
            y         <= '0;
            flush_cnt <= '0;
        end else begin
            if (start) begin
                x <= 11'd1;
                y <= '0;
            end else if (advance) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 11'd1;
                end else begin
                    x <= x + 11'd1;
                end
            end
            flush_cnt <= (state == FLUSH && state_nx == FLUSH) ? flush_cnt + 11'd1 : '0;
        end
    end

    // Centre position of the next emitted window, used for border and last flags
    always_ff @(posedge readClk or negedge rstN) begin
        if (!rstN) begin
            cx <= '0;
            cy <= '0;
        end else if (start) begin
            cx <= '0;
            cy <= '0;
        end else if (emit) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= cy + 11'd1;
            end else begin
                cx <= cx + 11'd1;
            end
        end
    end

    // Line buffers: line0 holds the previous row, line1 the row before it
    always_ff @(posedge readClk) begin
        if (advance) begin
            line1[addr] <= line0[addr];
            line0[addr] <= shift_pix;
        end
    end

    // Window columns shift left; the new right column is {row y-2, row y-1, incoming}
    always_ff @(posedge readClk or negedge rstN) begin
        if (!rstN) begin
            {lu, lm, ld, mu, mm, md, ru, rm, rd} <= '0;
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_last   <= 1'b0;
        end else begin
            if (advance) begin
                lu <= mu;  lm <= mm;  ld <= md;
                mu <= ru;  mm <= rm;  md <= rd;
                ru <= line1[addr];
                rm <= line0[addr];
                rd <= shift_pix;
            end
            win_valid  <= emit;
            win_border <= emit && (cx == '0 || cx == X_LAST || cy == '0 || cy == Y_LAST);
            win_last   <= emit && (cx == X_LAST) && (cy == Y_LAST);
        end
    end

    // Flag pipeline matching the filter latency; an aborted frame is flushed out of it
    always_ff @(posedge readClk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < FILT_LAT; i++) pipe[i] <= '0;
        end else if (clear_pipe) begin
            for (int unsigned i = 0; i < FILT_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {win_valid, win_border, win_last};
            for (int unsigned i = 1; i < FILT_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.pixReady  = ready_q;
    assign bus.winLu     = lu;
    assign bus.winLm     = lm;
    assign bus.winLd     = ld;
    assign bus.winMu     = mu;
    assign bus.winMm     = mm;
    assign bus.winMd     = md;
    assign bus.winRu     = ru;
    assign bus.winRm     = rm;
    assign bus.winRd     = rd;
    assign bus.winValid  = win_valid;
    assign bus.outValid  = pipe[FILT_LAT-1][2];
    assign bus.outLast   = pipe[FILT_LAT-1][2] & pipe[FILT_LAT-1][0];
    assign bus.useMedian = bus.enMedian & pipe[FILT_LAT-1][2] & ~pipe[FILT_LAT-1][1];
endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl on a 4x3 image with a 5-cycle filter latency.
module tb_median_window_ctrl;
    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 5;
    localparam int N = W * H;

    logic readClk = 1'b0;
    logic rstN    = 1'b0;

    median_window_ctrl_if bus ();

    median_window_ctrl #(.IMG_W(W), .IMG_H(H), .FILT_LAT(L)) dut (
        .readClk (readClk),
        .rstN    (rstN),
        .bus     (bus)
    );

    always #5 readClk = ~readClk;

    typedef struct {
        logic [107:0] win;
        logic [11:0]  mm;
        bit           border;
        int           after_acc;
        bit           expect_out;
    } win_exp_t;

    typedef struct {
        bit use_m;
        bit last;
    } out_exp_t;

    win_exp_t win_q[$];
    out_exp_t out_q[$];
    int       stamp_q[$];
    int       total = 0;
    int       bad   = 0;
    int       cycle = 0;
    int       acc   = 0;
    bit       acc_edge = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [107:0] win_now();
        return {bus.winLu, bus.winLm, bus.winLd, bus.winMu, bus.winMm, bus.winMd,
                bus.winRu, bus.winRm, bus.winRd};
    endfunction

    function automatic logic [112:0] outs_now();
        return {win_now(), bus.winValid, bus.useMedian, bus.outValid, bus.outLast, bus.pixReady};
    endfunction

    // Reference model: windows in raster order of centres, built directly from the image.
    // Window i of a frame follows acceptance i+W+2 while pixels remain, else it is a flush window.
    // An aborted frame (n_pix < N, driven back-to-back) only produces outputs for windows
    // emitted more than L cycles before the aborting pixel.
    task automatic expect_frame(input logic [11:0] img [N], input int n_pix, input bit en);
        bit full;
        int n_win;
        full  = (n_pix == N);
        n_win = full ? N : ((n_pix > W + 1) ? n_pix - W - 1 : 0);
        for (int i = 0; i < n_win; i++) begin
            int       cx = i % W;
            int       cy = i / W;
            int       k  = i + W + 2;
            win_exp_t e;
            e.border = (cx == 0) || (cx == W - 1) || (cy == 0) || (cy == H - 1);
            e.mm     = img[cy * W + cx];
            e.win    = '0;
            if (!e.border)
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        e.win = {e.win[95:0], img[(cy + dy) * W + cx + dx]};
            e.after_acc  = (k <= N) ? k : 0;
            e.expect_out = full || (n_pix + 1 - k > L);
            win_q.push_back(e);
            if (e.expect_out) out_q.push_back('{en && !e.border, full && (i == N - 1)});
        end
    endtask

    // Acceptance tracker: counts accepted pixels of the current frame at each rising edge
    initial forever begin
        @(posedge readClk);
        cycle++;
        acc_edge = bus.pixValid && bus.pixReady;
        if (!rstN) acc = 0;
        else if (acc_edge) begin
            if (bus.frameStart) acc = 1;
            else if (acc > 0)   acc++;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a window or a filter output
    initial begin
        win_exp_t e;
        out_exp_t o;
        int       s;
        forever begin
            @(negedge readClk);
            if (bus.winValid) begin
                if (win_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_window: got winValid=1 expected 0 (centre %h)", bus.winMm);
                end else begin
                    e = win_q.pop_front();
                    check("win_centre", 128'(bus.winMm), 128'(e.mm));
                    if (!e.border) check("win_full", 128'(win_now()), 128'(e.win));
                    if (e.after_acc != 0)
                        check("win_timing", acc_edge ? 128'(acc) : '1, 128'(e.after_acc));
                    if (e.expect_out) stamp_q.push_back(cycle);
                end
            end
            if (bus.outValid) begin
                if (out_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got outValid=1 expected 0");
                end else begin
                    o = out_q.pop_front();
                    check("use_median", 128'(bus.useMedian), 128'(o.use_m));
                    check("out_last", 128'(bus.outLast), 128'(o.last));
                    if (stamp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL out_latency: got output with no window expected a window first");
                    end else begin
                        s = stamp_q.pop_front();
                        check("out_latency", 128'(cycle - s), 128'(L));
                    end
                end
            end else begin
                check("idle_flags", 128'({bus.useMedian, bus.outLast}), '0);
            end
        end
    end

    task automatic drive_pixel(input logic [11:0] v, input bit fs);
        int guard = 0;
        @(negedge readClk);
        while (!bus.pixReady && guard < 100) begin
            bus.pixValid   = 1'b0;
            bus.frameStart = 1'b0;
            @(negedge readClk);
            guard++;
        end
        if (!bus.pixReady) begin
            total++; bad++;
            $display("FAIL ready_timeout: got pixReady=0 expected 1");
        end
        bus.pixIn      = v;
        bus.pixValid   = 1'b1;
        bus.frameStart = fs;
        @(posedge readClk);
    endtask

    // n idle cycles; after each one the window must be held and winValid low
    task automatic stall(input int n);
        logic [107:0] snap;
        @(negedge readClk);
        bus.pixValid   = 1'b0;
        bus.frameStart = 1'b0;
        snap = win_now();
        for (int j = 1; j < n; j++) begin
            @(negedge readClk);
            check("stall_valid", 128'(bus.winValid), '0);
            check("stall_hold", 128'(win_now()), 128'(snap));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((win_q.size() != 0 || out_q.size() != 0) && guard < 300) begin
            @(negedge readClk);
            guard++;
        end
        check("drain", 128'(win_q.size() + out_q.size()), '0);
        repeat (2) @(negedge readClk);
    endtask

    task automatic send_frame(input logic [11:0] img [N], input bit en, input int stall_pct,
                              input int stall_at, input bit do_drain);
        int low = 0;
        if (do_drain) drain();
        bus.enMedian = en;
        expect_frame(img, N, en);
        for (int p = 0; p < N; p++) begin
            if (p == stall_at) stall(3);
            else if (p > 0 && $urandom_range(99) < stall_pct) stall($urandom_range(4, 1));
            drive_pixel(img[p], p == 0);
        end
        @(negedge readClk);
        bus.pixValid   = 1'b0;
        bus.frameStart = 1'b0;
        while (!bus.pixReady && low < 50) begin
            low++;
            @(negedge readClk);
        end
        check("flush_ready_low", 128'(low), 128'(W + 1));
    endtask

    initial begin
        logic [11:0] img  [N];
        logic [11:0] imgx [N];
        bus.pixIn      = '0;
        bus.pixValid   = 1'b0;
        bus.frameStart = 1'b0;
        bus.enMedian   = 1'b0;

        repeat (3) @(negedge readClk);
        check("reset_outputs", 128'(outs_now()), '0);
        rstN = 1'b1;
        @(posedge readClk);
        #1 check("ready_after_reset", 128'(bus.pixReady), 128'(1));

        // Ramp frame 0x001..0x00C, median enabled, no gaps
        for (int i = 0; i < N; i++) img[i] = 12'(i + 1);
        send_frame(img, 1'b1, 0, -1, 1'b1);

        // Same frame, median disabled, 3-cycle gap in RUN
        send_frame(img, 1'b0, 0, 8, 1'b1);

        // frameStart on the 8th pixel aborts and restarts
        drain();
        bus.enMedian = 1'b1;
        for (int i = 0; i < N; i++) imgx[i] = 12'($urandom);
        for (int i = 0; i < N; i++) img[i]  = 12'($urandom);
        expect_frame(imgx, 7, 1'b1);
        for (int p = 0; p < 7; p++) drive_pixel(imgx[p], p == 0);
        send_frame(img, 1'b1, 0, -1, 1'b0);

        // Random frames with random gaps and stray pixels while idle
        repeat (5) begin
            drain();
            repeat ($urandom_range(3, 0)) drive_pixel(12'($urandom), 1'b0);
            for (int i = 0; i < N; i++) img[i] = 12'($urandom);
            send_frame(img, 1'($urandom_range(1, 0)), 30, -1, 1'b1);
        end

        // Reset asserted mid-RUN
        drain();
        for (int i = 0; i < N; i++) img[i] = 12'($urandom);
        expect_frame(img, 8, 1'b1);
        for (int p = 0; p < 8; p++) drive_pixel(img[p], p == 0);
        #2 rstN = 1'b0;
        #1 check("reset_async", 128'(outs_now()), '0);
        win_q.delete();
        out_q.delete();
        stamp_q.delete();
        bus.pixValid   = 1'b0;
        bus.frameStart = 1'b0;
        repeat (2) @(negedge readClk);
        check("reset_hold", 128'(outs_now()), '0);
        rstN = 1'b1;
        @(posedge readClk);
        #1 check("ready_after_reset2", 128'(bus.pixReady), 128'(1));
        repeat (6) begin
            drive_pixel(12'($urandom), 1'b0);
            #1 check("idle_after_reset", 128'({bus.winValid, bus.outValid}), '0);
        end
        for (int i = 0; i < N; i++) img[i] = 12'($urandom);
        send_frame(img, 1'b1, 20, -1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running expected completion");
        $fatal(1);
    end
endmodule

// File: doc/median_window_ctrl.md
MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

Parameters
REQ-001 SHALL have parameter IMG_W, default 640: pixels per line, range 4..2047.
REQ-002 SHALL have parameter IMG_H, default 480: lines per frame, range 3..2047.
REQ-003 SHALL have parameter FILT_LAT, default 5: clock cycles from a presented window to the filtered pixel.

Interface
REQ-004 SHALL have port readClk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rstN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port pixIn, input, 12 bits: RGB444 stream pixel, raster order.
REQ-007 SHALL have port pixValid, input, 1 bit: pixIn is valid.
REQ-008 SHALL have port frameStart, input, 1 bit: the current pixIn is pixel (0,0); qualified by pixValid.
REQ-009 SHALL have port pixReady, output, 1 bit: a pixel is accepted when pixValid and pixReady are both high.
REQ-010 SHALL have port enMedian, input, 1 bit: global median-filter enable.
REQ-011 SHALL have ports winLu, winLm, winLd, winMu, winMm, winMd, winRu, winRm, winRd, outputs, 12 bits each: registered 3x3 window (l/m/r = column x-1/x/x+1, u/m/d = row y-1/y/y+1) driving the filter inputs.
REQ-012 SHALL have port winValid, output, 1 bit: the window registers hold a new window this cycle.
REQ-013 SHALL have port useMedian, output, 1 bit: filter output-select, time-aligned with the filter output.
REQ-014 SHALL have port outValid, output, 1 bit: the filter output is a valid pixel this cycle.
REQ-015 SHALL have port outLast, output, 1 bit: the filter output is the final pixel of the frame (IMG_W*IMG_H-th).

Function
REQ-016 SHALL implement four states: IDLE, FILL, RUN, FLUSH.
REQ-017 SHALL buffer the two previous lines in two line buffers, each IMG_W x 12 bits.
REQ-018 SHALL track the input pixel position (x,y) with counters at least 11 bits wide; x wraps from IMG_W-1 to 0 and increments y on wrap.
REQ-019 SHALL, in IDLE, hold pixReady=1, discard accepted pixels without frameStart, and go to FILL on an accepted pixel with frameStart (that pixel is (0,0)).
REQ-020 SHALL, in FILL, accept pixels without asserting winValid; FILL consumes exactly IMG_W+1 pixels, then RUN is entered.
REQ-021 SHALL, in RUN, assert winValid on the cycle after each accepted pixel (x,y); the window is centred on (x-1,y-1), taking column wrap into account.
REQ-022 SHALL, on acceptance of pixel (IMG_W-1,IMG_H-1), enter FLUSH.
REQ-023 SHALL, in FLUSH, drive pixReady=0 and generate IMG_W+1 internal ticks; each tick shifts zero as input and asserts winValid; afterwards return to IDLE.
REQ-024 SHALL emit exactly IMG_W*IMG_H windows per frame, centres in raster order.
REQ-025 SHALL, when pixValid=0 in FILL or RUN, stall: no counter advance, window and line buffers held, winValid=0.
REQ-026 SHALL classify a window as border when its centre satisfies cx=0, cx=IMG_W-1, cy=0 or cy=IMG_H-1; border window contents outside the centre are don't-care.
REQ-027 SHALL carry {winValid, border, last} through a FILT_LAT-deep shift register that advances every cycle.
REQ-028 SHALL drive outValid and outLast from that shift register's final stage, exactly FILT_LAT cycles after the matching winValid.
REQ-029 SHALL drive useMedian = enMedian AND outValid AND NOT border from the same stage; enMedian is applied combinationally at the output.
REQ-030 SHALL, on an accepted pixel with frameStart in FILL or RUN, abort the frame: clear the shift register, restart counters with that pixel as (0,0), enter FILL; no outLast is issued for the aborted frame.
REQ-031 SHALL ignore frameStart in FLUSH, where pixReady=0.

Reset
REQ-032 SHALL, while rstN=0, force state to IDLE, x/y and flush counters to 0, the shift register to 0, all win* outputs to 0, and winValid, useMedian, outValid, outLast and pixReady to 0.
REQ-033 SHALL leave line-buffer contents unreset.
REQ-034 SHALL drive pixReady=1 on the first edge after rstN deasserts.

Verification (IMG_W=4, IMG_H=3, FILT_LAT=5)
REQ-035 SHALL cover: rstN low mid-RUN -> all outputs 0 immediately, state IDLE, no outValid until a new frameStart.
REQ-036 SHALL cover: 12 contiguous pixels, values 0x001..0x00C -> first winValid one cycle after the 6th acceptance with winMm=0x001; pixReady low 5 cycles after the 12th; 12 winValid total.
REQ-037 SHALL cover: the same frame with enMedian=1 -> 12 outValid pulses, each 5 cycles after its winValid; useMedian=1 only for centres (1,1) and (2,1); outLast on the 12th.
REQ-038 SHALL cover: pixValid low for 3 cycles in RUN -> winValid 0 for those cycles, win* outputs unchanged, frame still yields 12 outputs.
REQ-039 SHALL cover: frameStart asserted on the 8th pixel -> pipeline cleared, FILL restarts, next full frame yields 12 outputs with outLast once.
REQ-040 SHALL cover: enMedian=0 -> useMedian never asserted, outValid pattern identical to REQ-037.
